// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and unified-bus signals of mem_port_arbiter.
// Ports: if_* (fetch requester), d_* (data requester), mem_* (memory bus);
// modport master = arbiter side, modport slave = pipeline + memory side.
interface mem_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_ack;
    logic            if_err;
    logic            if_stall;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_sel;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            d_err;
    logic            d_stall;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_sel;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack, if_err, if_stall,
        input  d_req, d_we, d_addr, d_wdata, d_sel,
        output d_rdata, d_ack, d_err, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack, if_err, if_stall,
        output d_req, d_we, d_addr, d_wdata, d_sel,
        input  d_rdata, d_ack, d_err, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and data, data first,
// with a fetch anti-starvation guard and a bounded wait for mem_ack.
// Ports: clk, rst (async, active low), bus (mem_port_arbiter_if.master).
module mem_port_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_IF} state_t;

    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] wait_cnt;
    logic [CW-1:0] starve_cnt;
    logic          if_elig;
    logic          d_elig;
    logic          grant_d;
    logic          grant_if;
    logic          done;
    logic          abort;

    // A requester still seeing its ack this cycle holds a stale req.
    assign if_elig = bus.if_req & ~bus.if_ack;
    assign d_elig  = bus.d_req & ~bus.d_ack;

    assign bus.if_stall = bus.if_req & ~bus.if_ack;
    assign bus.d_stall  = bus.d_req & ~bus.d_ack;

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_elig && if_elig) begin
                    if (starve_cnt == CW'(STARVE_LIMIT))
                        grant_if = 1'b1;
                    else
                        grant_d = 1'b1;
                end else begin
                    grant_d  = d_elig;
                    grant_if = if_elig;
                end
                if (grant_d)
                    state_nx = BUSY_D;
                else if (grant_if)
                    state_nx = BUSY_IF;
            end
            BUSY_D, BUSY_IF: begin
                // mem_ack wins over a timeout hit in the same cycle.
                if (bus.mem_ack)
                    done = 1'b1;
                else if (wait_cnt == WW'(TIMEOUT - 1))
                    abort = 1'b1;
                if (done || abort)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_sel   <= '0;
            bus.if_rdata  <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            wait_cnt      <= '0;
            starve_cnt    <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.if_err <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.d_err  <= 1'b0;

            if (grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
                bus.mem_sel   <= bus.d_sel;
            end else if (grant_if) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
                bus.mem_sel   <= '1;
            end

            if (done || abort) begin
                bus.mem_req <= 1'b0;
                if (state == BUSY_D) begin
                    bus.d_ack   <= 1'b1;
                    bus.d_err   <= abort;
                    bus.d_rdata <= done ? bus.mem_rdata : '0;
                end else begin
                    bus.if_ack   <= 1'b1;
                    bus.if_err   <= abort;
                    bus.if_rdata <= done ? bus.mem_rdata : '0;
                end
            end

            if (state == IDLE)
                wait_cnt <= '0;
            else if (!bus.mem_ack)
                wait_cnt <= wait_cnt + WW'(1);

            if (!bus.if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int SL = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_port_arbiter #(
        .DW(DW), .AW(AW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: who owns the bus (0 none, 1 data, 2 fetch),
    // how long it has waited, and the starvation run length
    int            m_owner  = 0;
    int            m_waited = 0;
    int            m_starve = 0;
    logic          e_mem_req = 0, e_mem_we = 0;
    logic [AW-1:0] e_mem_addr = 0;
    logic [DW-1:0] e_mem_wdata = 0;
    logic [BW-1:0] e_mem_sel = 0;
    logic          e_if_ack = 0, e_if_err = 0;
    logic          e_d_ack = 0, e_d_err = 0;
    logic [DW-1:0] e_if_rdata = 0, e_d_rdata = 0;

    task automatic model_reset();
        m_owner = 0; m_waited = 0; m_starve = 0;
        e_mem_req = 0; e_if_ack = 0; e_if_err = 0;
        e_d_ack = 0; e_d_err = 0; e_if_rdata = 0; e_d_rdata = 0;
    endtask

    task automatic model_update();
        bit want_d, want_i, ok;
        int g;
        want_d = bus.d_req && !e_d_ack;
        want_i = bus.if_req && !e_if_ack;
        e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0;
        g = 0;
        if (m_owner != 0) begin
            if (bus.mem_ack || m_waited + 1 == TO) begin
                ok = bus.mem_ack;
                if (m_owner == 1) begin
                    e_d_ack = 1; e_d_err = !ok;
                    e_d_rdata = ok ? bus.mem_rdata : '0;
                end else begin
                    e_if_ack = 1; e_if_err = !ok;
                    e_if_rdata = ok ? bus.mem_rdata : '0;
                end
                m_owner = 0;
                e_mem_req = 0;
            end else begin
                m_waited++;
            end
        end else begin
            if (want_d && want_i) g = (m_starve >= SL) ? 2 : 1;
            else if (want_d) g = 1;
            else if (want_i) g = 2;
            if (g == 1) begin
                e_mem_req = 1; e_mem_we = bus.d_we; e_mem_addr = bus.d_addr;
                e_mem_wdata = bus.d_wdata; e_mem_sel = bus.d_sel;
            end else if (g == 2) begin
                e_mem_req = 1; e_mem_we = 0; e_mem_addr = bus.if_addr;
                e_mem_sel = '1;
            end
            m_owner = g;
            m_waited = 0;
        end
        if (!bus.if_req || g == 2) m_starve = 0;
        else if (g == 1 && m_starve < SL) m_starve++;
    endtask

    task automatic compare_all();
        check("mem_req", bus.mem_req, e_mem_req);
        if (e_mem_req) begin
            check("mem_we", bus.mem_we, e_mem_we);
            check("mem_addr", bus.mem_addr, e_mem_addr);
            check("mem_sel", bus.mem_sel, e_mem_sel);
            if (e_mem_we) check("mem_wdata", bus.mem_wdata, e_mem_wdata);
        end
        check("if_ack", bus.if_ack, e_if_ack);
        check("if_err", bus.if_err, e_if_err);
        check("if_rdata", bus.if_rdata, e_if_rdata);
        check("d_ack", bus.d_ack, e_d_ack);
        check("d_err", bus.d_err, e_d_err);
        check("d_rdata", bus.d_rdata, e_d_rdata);
        check("if_stall", bus.if_stall, bus.if_req & ~e_if_ack);
        check("d_stall", bus.d_stall, bus.d_req & ~e_d_ack);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_update();
        @(negedge clk);
        if (rst) compare_all();
    endtask

    // memory slave: lat_fix >= 0 fixes the ack delay, stray 1 = random
    // acks while idle, stray 2 = mem_ack tied high
    int            lat_fix = -1;
    int            stray = 0;
    bit            use_fix = 0;
    logic [DW-1:0] rdata_fix = 0;
    bit            in_txn = 0;
    int            cyc = 0;
    int            lat = 0;

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 4;
        if (r < 17) return TO - 1;
        if (r < 19) return TO - 2;
        return 40;
    endfunction

    task automatic slave_drive();
        if (bus.mem_req) begin
            if (!in_txn) begin
                in_txn = 1; cyc = 0;
                lat = (lat_fix >= 0) ? lat_fix : pick_lat();
            end
            bus.mem_ack = (cyc == lat) || (stray == 2);
            cyc++;
        end else begin
            in_txn = 0;
            bus.mem_ack = (stray == 2) ||
                          (stray == 1 && $urandom_range(0, 7) == 0);
        end
        bus.mem_rdata = use_fix ? rdata_fix : DW'($urandom);
    endtask

    task automatic new_d();
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = AW'($urandom);
        bus.d_wdata = DW'($urandom);
        bus.d_sel = BW'($urandom);
    endtask

    task automatic req_drive();
        if (!bus.d_req) begin
            if ($urandom_range(0, 2) == 0) begin bus.d_req = 1; new_d(); end
        end else if (bus.d_ack) begin
            if ($urandom_range(0, 1) == 1) bus.d_req = 0;
            else new_d();
        end
        if (!bus.if_req) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.if_req = 1; bus.if_addr = AW'($urandom);
            end
        end else if (bus.if_ack) begin
            if ($urandom_range(0, 1) == 1) bus.if_req = 0;
            else bus.if_addr = AW'($urandom);
        end
    endtask

    initial begin
        int n, hi, alt_bad, last, kind, first;
        bit dseen, iseen;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_wdata = 0; bus.d_sel = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_if_ack", bus.if_ack, 0);
        rst = 1;

        // reset in the middle of a data transaction
        lat_fix = 100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; bus.d_sel = 4'hF;
        step(); slave_drive();
        check("rm_granted", bus.mem_req, 1);
        @(posedge clk); #2 rst = 0; #1;
        model_reset();
        check("rm_mem_req", bus.mem_req, 0);
        check("rm_d_ack", bus.d_ack, 0);
        bus.d_req = 0;
        @(negedge clk); rst = 1; slave_drive();
        repeat (3) begin
            step();
            check("rm_idle", bus.mem_req, 0);
            slave_drive();
        end

        // single fetch
        lat_fix = 2; use_fix = 1; rdata_fix = 32'h34010005;
        bus.if_req = 1; bus.if_addr = 32'h4;
        n = 0;
        while (!bus.if_ack && n < 20) begin
            step(); n++;
            if (bus.mem_req) begin
                check("f_sel", bus.mem_sel, 4'hF);
                check("f_we", bus.mem_we, 0);
                check("f_addr", bus.mem_addr, 32'h4);
            end
            slave_drive();
        end
        check("f_latency", n, 4);
        check("f_ack", bus.if_ack, 1);
        check("f_rdata", bus.if_rdata, 32'h34010005);
        check("f_err", bus.if_err, 0);
        step();
        check("f_no_reissue", bus.mem_req, 0);
        check("f_ack_pulse", bus.if_ack, 0);
        bus.if_req = 0; slave_drive();

        // simultaneous requests: data first, then fetch
        lat_fix = 1; use_fix = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEADBEEF; bus.d_sel = 4'h3;
        bus.if_req = 1; bus.if_addr = 32'h8;
        first = 0; dseen = 0; iseen = 0; n = 0;
        while (!(dseen && iseen) && n < 30) begin
            step(); n++;
            if (bus.mem_req && !dseen) begin
                check("s_we", bus.mem_we, 1);
                check("s_sel", bus.mem_sel, 4'h3);
                check("s_addr", bus.mem_addr, 32'h100);
                check("s_wdata", bus.mem_wdata, 32'hDEADBEEF);
                check("s_if_stall", bus.if_stall, 1);
            end else if (bus.mem_req) begin
                check("s_f_addr", bus.mem_addr, 32'h8);
                check("s_f_sel", bus.mem_sel, 4'hF);
            end
            if (bus.d_ack) begin
                if (first == 0) first = 1;
                dseen = 1; bus.d_req = 0;
            end
            if (bus.if_ack) begin
                if (first == 0) first = 2;
                iseen = 1; bus.if_req = 0;
            end
            slave_drive();
        end
        check("s_order", first, 1);
        check("s_both", dseen && iseen, 1);
        step(); slave_drive();

        // timeout without mem_ack, then ack on the last allowed cycle
        for (int k = 0; k < 2; k++) begin
            lat_fix = (k == 0) ? 100 : TO - 1;
            use_fix = 1; rdata_fix = 32'hA5A50001;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
            hi = 0; n = 0;
            while (!bus.d_ack && n < 30) begin
                step(); n++;
                if (bus.mem_req) hi++;
                slave_drive();
            end
            check("t_busy_cycles", hi, TO);
            check("t_ack", bus.d_ack, 1);
            check("t_err", bus.d_err, (k == 0) ? 1 : 0);
            check("t_rdata", bus.d_rdata, (k == 0) ? 32'h0 : 32'hA5A50001);
            bus.d_req = 0;
            step(); slave_drive();
        end

        // zero-wait bus under continuous dual requests
        stray = 2; lat_fix = 0; use_fix = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_sel = 4'h3; bus.d_addr = 32'h300;
        bus.if_req = 1; bus.if_addr = 32'h10;
        hi = 0; alt_bad = 0; last = 0;
        repeat (20) begin
            step();
            if (bus.mem_req) begin
                hi++;
                kind = (bus.mem_sel == 4'hF && !bus.mem_we) ? 2 : 1;
                if (kind == last) alt_bad++;
                last = kind;
            end
            if (bus.d_ack) bus.d_addr = bus.d_addr + 32'h4;
            if (bus.if_ack) bus.if_addr = bus.if_addr + 32'h4;
            slave_drive();
        end
        check("z_rate", hi, 10);
        check("z_alternate", alt_bad, 0);
        bus.d_req = 0; bus.if_req = 0;
        stray = 0;
        step(); slave_drive();

        // random traffic
        stray = 1; lat_fix = -1;
        repeat (3000) begin
            step();
            req_drive();
            slave_drive();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
